// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: SRAM command/response bus between the arbiter and sram_iface.
// Ports (modport master = arbiter side):
//   start      one-cycle command strobe
//   writemode  1=write, 0=read
//   sram_addr  access address
//   sram_wdata write data
//   io_done    completion pulse from sram_iface
//   r_data     read data from sram_iface
interface sram_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              start;
    logic              writemode;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic              io_done;
    logic [DATA_W-1:0] r_data;
    modport master (output start, writemode, sram_addr, sram_wdata, input io_done, r_data);
    modport slave  (input start, writemode, sram_addr, sram_wdata, output io_done, r_data);
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter sharing one sram_iface port among NUM_REQ clients.
// Ports:
//   clk, n_rst            clock, asynchronous active-low reset
//   req/req_wr            per-client level request and write flag
//   req_addr/req_wdata    packed per-client address and write data
//   gnt                   one-hot grant, high from grant until done
//   done                  one-cycle completion pulse to the winner
//   rdata                 registered read data, valid with done
//   err_timeout           sticky watchdog error (0 unless SRAM_ARB_TIMEOUT_EN)
//   sram                  sram_arbiter_if master modport
// Optional feature: define SRAM_ARB_TIMEOUT_EN to enable the WAIT watchdog.
module sram_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_wr,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rdata,
    output logic                      err_timeout,
    sram_arbiter_if.master            sram
);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2;
    logic [1:0]        state;
    logic [IW-1:0]     rr_ptr, g, pick;
    logic [IW:0]       idx;
    logic              any, fin, expire;
    logic              lat_wr;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    // Scan offsets from the top down so the lowest offset from rr_ptr wins.
    always_comb begin
        pick = '0;
        any  = 1'b0;
        idx  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr} + (IW+1)'(k);
            idx = (idx >= (IW+1)'(NUM_REQ)) ? idx - (IW+1)'(NUM_REQ) : idx;
            if (req[idx[IW-1:0]]) begin
                pick = idx[IW-1:0];
                any  = 1'b1;
            end
        end
    end
    assign fin             = (state == WAIT) && (sram.io_done || expire);
    assign sram.start      = (state == ISSUE);
    assign sram.writemode  = lat_wr;
    assign sram.sram_addr  = lat_addr;
    assign sram.sram_wdata = lat_wdata;
`ifdef SRAM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    // cnt is 1 in the first WAIT cycle, so expiry lands TIMEOUT_CYCLES cycles after ISSUE.
    assign expire = (state == WAIT) && (cnt == CW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt         <= '0;
            err_timeout <= 1'b0;
        end else begin
            cnt         <= (state == ISSUE) ? CW'(1) : (state == WAIT) ? cnt + CW'(1) : '0;
            err_timeout <= err_timeout | (expire & ~sram.io_done);
        end
    end
`else
    assign expire      = 1'b0;
    assign err_timeout = 1'b0;
`endif
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            g         <= '0;
            gnt       <= '0;
            done      <= '0;
            rdata     <= '0;
            lat_wr    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            done <= '0;
            if (state == IDLE && any) begin
                g         <= pick;
                gnt       <= NUM_REQ'(1) << pick;
                lat_wr    <= req_wr[pick];
                lat_addr  <= req_addr[pick*ADDR_W +: ADDR_W];
                lat_wdata <= req_wdata[pick*DATA_W +: DATA_W];
                state     <= ISSUE;
            end
            if (state == ISSUE) state <= WAIT;
            if (fin) begin
                done   <= NUM_REQ'(1) << g;
                gnt    <= '0;
                rr_ptr <= (g == IW'(NUM_REQ - 1)) ? '0 : g + IW'(1);
                state  <= IDLE;
                if (sram.io_done && !lat_wr) rdata <= sram.r_data;
            end
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed self-checking bench for sram_arbiter.
module tb_sram_arbiter;
    localparam int N = 3, AW = 16, DW = 8;
    logic clk = 1'b0, n_rst = 1'b0;
    logic [N-1:0] req = '0, req_wr = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0] gnt, done;
    logic [DW-1:0] rdata;
    logic err_timeout;
    int checks = 0, errors = 0;
    sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    sram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .n_rst(n_rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata),
        .err_timeout(err_timeout), .sram(bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask
    // Serves one transaction: waits for start, checks the command, answers io_done 3 cycles after start.
    task automatic xact(input int who, input logic [AW-1:0] a, input logic w,
                        input logic [DW-1:0] wd, input logic [DW-1:0] rd, input logic mut);
        int n = 0;
        while (!bus.start && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("start_seen", 32'(bus.start), 1);
        check("gnt", 32'(gnt), 32'(1 << who));
        check("gnt_onehot", $countones(gnt), 1);
        check("addr", 32'(bus.sram_addr), 32'(a));
        check("wmode", 32'(bus.writemode), 32'(w));
        if (w) check("wdata", 32'(bus.sram_wdata), 32'(wd));
        @(negedge clk);
        check("start_pulse", 32'(bus.start), 0);
        if (mut) req_addr[who*AW +: AW] = ~a;
        @(negedge clk);
        check("addr_hold", 32'(bus.sram_addr), 32'(a));
        check("wmode_hold", 32'(bus.writemode), 32'(w));
        if (w) check("wdata_hold", 32'(bus.sram_wdata), 32'(wd));
        @(negedge clk);
        bus.io_done = 1'b1;
        bus.r_data  = rd;
        @(negedge clk);
        bus.io_done = 1'b0;
        check("done", 32'(done), 32'(1 << who));
        check("gnt_clr", 32'(gnt), 0);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end
    initial begin
        bus.io_done = 1'b0;
        bus.r_data  = '0;
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rdata", 32'(rdata), 0);
        check("rst_start", 32'(bus.start), 0);
        check("rst_wmode", 32'(bus.writemode), 0);
        check("rst_addr", 32'(bus.sram_addr), 0);
        check("rst_wdata", 32'(bus.sram_wdata), 0);
        check("rst_err", 32'(err_timeout), 0);
        n_rst = 1'b1;
        @(negedge clk);
        req_addr[0 +: AW] = 16'h1234;
        req = 3'b001;
        xact(0, 16'h1234, 1'b0, 8'h00, 8'hA5, 1'b0);
        req = '0;
        check("read_rdata", 32'(rdata), 32'hA5);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 0);
        req_addr[2*AW +: AW] = 16'h00FF;
        req_wdata[2*DW +: DW] = 8'h3C;
        req_wr = 3'b100;
        req = 3'b100;
        xact(2, 16'h00FF, 1'b1, 8'h3C, 8'h77, 1'b0);
        req = '0;
        check("write_rdata_kept", 32'(rdata), 32'hA5);
        req_wr = '0;
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = 16'h0100 + AW'(i);
        req = 3'b111;
        for (int i = 0; i < 6; i++) begin
            xact(i % 3, 16'h0100 + AW'(i % 3), 1'b0, 8'h00, 8'(i + 1), 1'b0);
            check("rr_rdata", 32'(rdata), 32'(i + 1));
        end
        req = '0;
        req_addr[AW +: AW] = 16'h0010;
        req = 3'b010;
        xact(1, 16'h0010, 1'b0, 8'h00, 8'h5A, 1'b1);
        req = '0;
        check("latch_rdata", 32'(rdata), 32'h5A);
        @(negedge clk);
        req = 3'b100;
        @(negedge clk);
        check("pre_rst_start", 32'(bus.start), 1);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        check("arst_gnt", 32'(gnt), 0);
        check("arst_start", 32'(bus.start), 0);
        check("arst_addr", 32'(bus.sram_addr), 0);
        check("arst_rdata", 32'(rdata), 0);
        @(negedge clk);
        req_addr[AW +: AW] = 16'h0011;
        req = 3'b110;
        n_rst = 1'b1;
        xact(1, 16'h0011, 1'b0, 8'h00, 8'h11, 1'b0);
        req = 3'b100;
        xact(2, 16'h0102, 1'b0, 8'h00, 8'h22, 1'b0);
        req = '0;
        check("post_rst_rdata", 32'(rdata), 32'h22);
        @(negedge clk);
        bus.io_done = 1'b1;
        bus.r_data  = 8'hEE;
        @(negedge clk);
        bus.io_done = 1'b0;
        check("idle_iodone_done", 32'(done), 0);
        check("idle_iodone_rdata", 32'(rdata), 32'h22);
        check("idle_iodone_start", 32'(bus.start), 0);
`ifdef SRAM_ARB_TIMEOUT_EN
        begin
            int n = 0;
            req = 3'b001;
            @(negedge clk);
            check("to_start", 32'(bus.start), 1);
            while (done == '0 && n < 30) begin
                @(negedge clk);
                n++;
            end
            req = '0;
            check("to_latency", 32'(n), 8);
            check("to_done", 32'(done), 1);
            check("to_err", 32'(err_timeout), 1);
            check("to_rdata", 32'(rdata), 32'h22);
            @(negedge clk);
            req = 3'b010;
            xact(1, 16'h0011, 1'b0, 8'h00, 8'h33, 1'b0);
            req = '0;
            check("to_after_rdata", 32'(rdata), 32'h33);
            check("to_err_sticky", 32'(err_timeout), 1);
        end
`endif
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
